// File: rtl/reg_file_2r1w_if.sv
// Bus bundle for reg_file_2r1w: one write/clear port and two enabled read ports.
// The master drives requests; the slave (the register file) returns data and valid strobes.
interface reg_file_2r1w_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);

  logic              clear;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  logic              re_a;
  logic [ADDR_W-1:0] raddr_a;
  logic [DATA_W-1:0] rdata_a;
  logic              rvalid_a;

  logic              re_b;
  logic [ADDR_W-1:0] raddr_b;
  logic [DATA_W-1:0] rdata_b;
  logic              rvalid_b;

  modport master (
    output clear, we, waddr, wdata,
    output re_a, raddr_a, re_b, raddr_b,
    input  rdata_a, rvalid_a, rdata_b, rvalid_b
  );

  modport slave (
    input  clear, we, waddr, wdata,
    input  re_a, raddr_a, re_b, raddr_b,
    output rdata_a, rvalid_a, rdata_b, rvalid_b
  );

endinterface

// File: rtl/reg_file_2r1w.sv
// Parametrised register file: one write port, two registered read ports (1-cycle latency), sync clear.
// Define REG_FILE_BYPASS_EN for write-first collisions and zero reads in a clear cycle; otherwise read-first.
module reg_file_2r1w #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  reg_file_2r1w_if.slave        bus
);

  localparam logic [ADDR_W:0] LP_NUM_REGS = (ADDR_W + 1)'(NUM_REGS);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] r_rdata_a;
  logic [DATA_W-1:0] r_rdata_b;
  logic              r_rvalid_a;
  logic              r_rvalid_b;

  logic              w_waddr_ok;
  logic              w_wr_hit;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;

  assign w_waddr_ok = ({1'b0, bus.waddr} < LP_NUM_REGS);
  assign w_wr_hit   = bus.we && w_waddr_ok;

  // Addresses beyond the implemented registers match no entry and read as zero.
  function automatic logic [DATA_W-1:0] array_read(input logic [ADDR_W-1:0] addr);
    array_read = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == ADDR_W'(i)) array_read = r_regs[i];
    end
  endfunction

  // NOTE: every signal assigned in always_comb gets an unconditional default first so no latch is inferred.
  always_comb begin
    w_rd_a = array_read(bus.raddr_a);
    w_rd_b = array_read(bus.raddr_b);
`ifdef REG_FILE_BYPASS_EN
    if (bus.clear) begin
      w_rd_a = '0;
      w_rd_b = '0;
    end else begin
      if (w_wr_hit && (bus.waddr == bus.raddr_a)) w_rd_a = bus.wdata;
      if (w_wr_hit && (bus.waddr == bus.raddr_b)) w_rd_b = bus.wdata;
    end
`endif
  end

  // NOTE: the array is reset because reset must leave every register at zero; this forces flops, not a RAM macro.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (bus.clear) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_hit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (bus.waddr == ADDR_W'(i)) r_regs[i] <= bus.wdata;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata_a  <= '0;
      r_rvalid_a <= 1'b0;
    end else begin
      r_rvalid_a <= bus.re_a;
      if (bus.re_a) r_rdata_a <= w_rd_a;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata_b  <= '0;
      r_rvalid_b <= 1'b0;
    end else begin
      r_rvalid_b <= bus.re_b;
      if (bus.re_b) r_rdata_b <= w_rd_b;
    end
  end

  assign bus.rdata_a  = r_rdata_a;
  assign bus.rvalid_a = r_rvalid_a;
  assign bus.rdata_b  = r_rdata_b;
  assign bus.rvalid_b = r_rvalid_b;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench for reg_file_2r1w (NUM_REGS=6, ADDR_W=3, so addresses 6..7 are out of range).
// Expected read data comes from an array model; a negedge monitor pops and compares on rvalid.
`timescale 1ns/1ps
module tb_reg_file_2r1w;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 6;

  typedef struct {
    int unsigned       cyc;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b1;
  int unsigned cyc     = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  logic [DATA_W-1:0] model [NUM_REGS];
  exp_t              exp_q [2][$];
  logic [DATA_W-1:0] held  [2];

  reg_file_2r1w_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_file_2r1w #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] ref_read(input int addr, input bit clr, input bit we,
                                                 input int waddr, input logic [DATA_W-1:0] wdata);
    if (addr >= NUM_REGS) return '0;
`ifdef REG_FILE_BYPASS_EN
    if (clr) return '0;
    if (we && waddr == addr) return wdata;
`else
    if (clr || we || waddr != 0 || wdata != '0) begin end
`endif
    return model[addr];
  endfunction

  task automatic step(input bit clr, input bit we, input int waddr, input logic [DATA_W-1:0] wdata,
                      input bit re_a, input int ra, input bit re_b, input int rb);
    exp_t e;
    bus.clear   = clr;
    bus.we      = we;
    bus.waddr   = ADDR_W'(waddr);
    bus.wdata   = wdata;
    bus.re_a    = re_a;
    bus.raddr_a = ADDR_W'(ra);
    bus.re_b    = re_b;
    bus.raddr_b = ADDR_W'(rb);
    if (re_a) begin
      e.cyc = cyc; e.data = ref_read(ra, clr, we, waddr, wdata);
      exp_q[0].push_back(e);
    end
    if (re_b) begin
      e.cyc = cyc; e.data = ref_read(rb, clr, we, waddr, wdata);
      exp_q[1].push_back(e);
    end
    if (clr) begin
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    end else if (we && waddr < NUM_REGS) begin
      model[waddr] = wdata;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    bus.clear   = 1'b0;
    bus.we      = 1'b0;
    bus.re_a    = 1'b0;
    bus.re_b    = 1'b0;
    #1;
    exp_q[0].delete();
    exp_q[1].delete();
    held[0] = '0;
    held[1] = '0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    check("reset_rvalid_a", 64'(bus.rvalid_a), 64'd0);
    check("reset_rvalid_b", 64'(bus.rvalid_b), 64'd0);
    check("reset_rdata_a",  64'(bus.rdata_a),  64'd0);
    check("reset_rdata_b",  64'(bus.rdata_b),  64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic mon_port(input int p, input logic v, input logic [DATA_W-1:0] d);
    exp_t e;
    while (exp_q[p].size() > 0 && exp_q[p][0].cyc + 1 < cyc) begin
      e = exp_q[p].pop_front();
      n_checks++;
      n_errors++;
      $display("FAIL port%0d_rvalid_missing: rvalid=0 required=1 for read issued in cycle %0d", p, e.cyc);
    end
    if (v) begin
      if (exp_q[p].size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL port%0d_rvalid_unexpected: rvalid=1 required=0 in cycle %0d", p, cyc);
      end else begin
        e = exp_q[p].pop_front();
        check($sformatf("port%0d_latency", p), 64'(cyc), 64'(e.cyc + 1));
        check($sformatf("port%0d_rdata", p), 64'(d), 64'(e.data));
        held[p] = e.data;
      end
    end else begin
      check($sformatf("port%0d_hold", p), 64'(d), 64'(held[p]));
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      mon_port(0, bus.rvalid_a, bus.rdata_a);
      mon_port(1, bus.rvalid_b, bus.rdata_b);
    end
  end

  initial begin
    logic [DATA_W-1:0] v;
    held[0] = '0;
    held[1] = '0;
    #2;
    do_reset();

    // Reading a register straight after reset returns zero.
    step(0, 0, 0, '0, 1, 5, 1, 5);
    idle(1);

    // Write/read sweep across the full address space, including the two unimplemented addresses.
    for (int i = 0; i < 8; i++) begin
      v = DATA_W'(i) * 32'h1111_1111;
      step(0, 1, i, v, 0, 0, 0, 0);
    end
    for (int i = 0; i < 8; i++) step(0, 0, 0, '0, 1, i, 1, 7 - i);
    idle(1);

    // Read/write collision on reg3, then a plain read of reg3.
    step(0, 1, 3, 32'hAAAA_0000, 0, 0, 0, 0);
    step(0, 1, 3, 32'h1234_5678, 1, 3, 0, 0);
    step(0, 0, 0, '0, 1, 3, 1, 3);
    idle(1);

    // Clear beats a same-cycle write; a read in the clear cycle follows the build's rule.
    step(1, 1, 2, 32'h0000_FFFF, 1, 2, 1, 4);
    for (int i = 0; i < NUM_REGS; i++) step(0, 0, 0, '0, 1, i, 1, NUM_REGS - 1 - i);
    idle(1);

    // Out-of-range write is dropped and out-of-range read returns zero with valid.
    for (int i = 0; i < NUM_REGS; i++) step(0, 1, i, 32'hC0DE_0000 + DATA_W'(i), 0, 0, 0, 0);
    step(0, 1, 7, 32'h0000_DEAD, 0, 0, 0, 0);
    step(0, 0, 0, '0, 1, 7, 1, 6);
    for (int i = 0; i < NUM_REGS; i++) step(0, 0, 0, '0, 1, i, 1, i);
    idle(1);

    // Single-cycle strobe and held data.
    step(0, 1, 1, 32'h0000_0055, 0, 0, 0, 0);
    step(0, 0, 0, '0, 1, 1, 0, 0);
    idle(4);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(19) == 0), ($urandom_range(1) == 1), int'($urandom_range(7)), $urandom(),
           ($urandom_range(9) < 7), int'($urandom_range(7)),
           ($urandom_range(9) < 7), int'($urandom_range(7)));
    end

    // Reset while reads are in flight: their rvalid never appears.
    step(0, 1, 0, 32'hFEED_BEEF, 1, 1, 1, 2);
    do_reset();
    step(0, 0, 0, '0, 1, 0, 1, 5);
    for (int n = 0; n < 40; n++) begin
      step(0, ($urandom_range(1) == 1), int'($urandom_range(7)), $urandom(),
           ($urandom_range(1) == 1), int'($urandom_range(7)),
           ($urandom_range(1) == 1), int'($urandom_range(7)));
    end
    idle(3);

    check("queue_a_drained", 64'(exp_q[0].size()), 64'd0);
    check("queue_b_drained", 64'(exp_q[1].size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
